// File: rtl/led_pkg.sv
// Shared constants for the RGB LED switch panel path: colour field
// boundaries inside the 16-bit panel word and the debounce state encoding.
package led_pkg;

    localparam int unsigned PANEL_W = 16;
    localparam int unsigned RED_MSB = 15;
    localparam int unsigned RED_LSB = 11;
    localparam int unsigned GRN_MSB = 10;
    localparam int unsigned GRN_LSB = 5;
    localparam int unsigned BLU_MSB = 4;
    localparam int unsigned BLU_LSB = 0;

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } settle_state_e;

endpackage

// File: rtl/switch_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous inputs.
// Both stages clear on the synchronous active-high reset.
module switch_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync_a_r;
    logic [W-1:0] sync_b_r;

    // Two-stage metastability filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_r <= {W{1'b0}};
            sync_b_r <= {W{1'b0}};
        end else begin
            sync_a_r <= d;
            sync_b_r <= sync_a_r;
        end
    end

    assign q = sync_b_r;

endmodule

// File: rtl/switch_panel_debounce.sv
// Panel-wide debouncer for the 16-bit slide-switch bank feeding the LED driver.
// The synchronised panel must hold one value for DEBOUNCE_CYCLES consecutive
// samples before it is committed to switchPanel; any bounce on any bit
// restarts the settle for the whole word.
// Optional feature macro: SWITCH_PANEL_PULSE_EN adds the panelUpdate pulse.
module switch_panel_debounce
    import led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PANEL_W-1:0] rawSwitch,
    output logic [PANEL_W-1:0] switchPanel,
    output logic               stable
`ifdef SWITCH_PANEL_PULSE_EN
    ,
    output logic               panelUpdate
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 32'd1);
    // The sample that detects the change counts as the first settled cycle,
    // so the commit edge is reached when the counter shows DEBOUNCE_CYCLES-2.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (DEBOUNCE_CYCLES >= 32'd2) ? CNT_W'(DEBOUNCE_CYCLES - 32'd2) : {CNT_W{1'b0}};
    // With a one-cycle settle the detecting sample already satisfies it.
    localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 32'd1);

    logic [PANEL_W-1:0] sync_b_s;
    settle_state_e      state_r;
    settle_state_e      state_s;
    logic [PANEL_W-1:0] cand_r;
    logic [PANEL_W-1:0] cand_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [PANEL_W-1:0] panel_r;
    logic [PANEL_W-1:0] panel_s;
    logic               stable_r;
    logic               pulse_s;

    switch_sync #(
        .W (PANEL_W)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rawSwitch),
        .q   (sync_b_s)
    );

    // Next-state, candidate, counter and commit decision.
    always_comb begin
        state_s = state_r;
        cand_s  = cand_r;
        cnt_s   = cnt_r;
        panel_s = panel_r;
        pulse_s = 1'b0;
        case (state_r)
            STABLE: begin
                if (sync_b_s != panel_r) begin
                    cand_s = sync_b_s;
                    cnt_s  = {CNT_W{1'b0}};
                    if (SINGLE_CYCLE) begin
                        panel_s = sync_b_s;
                        pulse_s = 1'b1;
                        state_s = STABLE;
                    end else begin
                        state_s = SETTLE;
                    end
                end else begin
                    state_s = STABLE;
                end
            end
            SETTLE: begin
                if (sync_b_s != cand_r) begin
                    cand_s = sync_b_s;
                    cnt_s  = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    panel_s = cand_r;
                    pulse_s = (cand_r != panel_r);
                    state_s = STABLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_s = STABLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, candidate, counter and registered panel/stable outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= STABLE;
            cand_r   <= {PANEL_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            panel_r  <= {PANEL_W{1'b0}};
            stable_r <= 1'b1;
        end else begin
            state_r  <= state_s;
            cand_r   <= cand_s;
            cnt_r    <= cnt_s;
            panel_r  <= panel_s;
            stable_r <= (state_s == STABLE);
        end
    end

    assign switchPanel = panel_r;
    assign stable      = stable_r;

`ifdef SWITCH_PANEL_PULSE_EN
    logic pulse_r;

    // One-cycle change pulse aligned with the newly committed panel value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_r <= 1'b0;
        end else begin
            pulse_r <= pulse_s;
        end
    end

    assign panelUpdate = pulse_r;
`else
    logic unused_pulse_s;
    assign unused_pulse_s = pulse_s;
`endif

endmodule
